// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus arbiter.
// Optional feature macro used by cdb_arbiter: CDB_MEM_PRIO_EN.
package cdb_pkg;

  localparam int CDB_N_UNIT = 4;
  localparam int CDB_DATA_W = 32;
  localparam int CDB_TAG_W  = 4;

  // An all-ones tag marks "no instruction" on the bus and in the request lanes.
  localparam logic [CDB_TAG_W-1:0] TAG_INVALID = '1;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
    logic                  rd;
  } cdb_entry_t;

  // Pointer width for an N-way round robin; at least one bit so N=1 still elaborates.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin search: the first requester at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          gnt_valid_o,
  output logic [PW-1:0] gnt_idx_o
);

  int  idx;
  logic found;

  // Scan N positions starting at the pointer and take the first request seen.
  always_comb begin
    gnt_o       = '0;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    found       = 1'b0;
    idx         = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        gnt_o[idx]   = 1'b1;
        gnt_idx_o    = PW'(idx);
      end
    end
    gnt_valid_o = found;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one single-entry slot per execution unit, a
// round-robin scheduler and a registered broadcast bus with flush support.
// Optional feature macro: CDB_MEM_PRIO_EN (slot MEM_UNIT wins whenever occupied).
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int N_UNIT   = CDB_N_UNIT,
  parameter int DATA_W   = CDB_DATA_W,
  parameter int TAG_W    = CDB_TAG_W,
  parameter int MEM_UNIT = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rst_tag,
  input  logic [N_UNIT-1:0]              req_valid,
  output logic [N_UNIT-1:0]              req_ready,
  input  logic [N_UNIT-1:0][TAG_W-1:0]   req_tag,
  input  logic [N_UNIT-1:0][DATA_W-1:0]  req_data,
  input  logic [N_UNIT-1:0]              req_rd,
  output logic                           cdb_valid,
  output logic [TAG_W-1:0]               cdb_tag,
  output logic [DATA_W-1:0]              cdb_data,
  output logic                           cdb_rd
);

  localparam int PW = ptr_width(N_UNIT);
  // Same all-ones pattern as TAG_INVALID, sized to this instance's tag width.
  localparam logic [TAG_W-1:0] TAG_NONE = '1;
  localparam logic [PW-1:0]    LAST_IDX = PW'(N_UNIT - 1);
  localparam logic [PW-1:0]    MEM_IDX  = PW'(MEM_UNIT);

`ifdef CDB_MEM_PRIO_EN
  localparam bit MEM_PRIO = 1'b1;
`else
  localparam bit MEM_PRIO = 1'b0;
`endif

  logic [N_UNIT-1:0]             occ_q, occ_d;
  logic [N_UNIT-1:0][TAG_W-1:0]  tag_q;
  logic [N_UNIT-1:0][DATA_W-1:0] data_q;
  logic [N_UNIT-1:0]             rd_q;
  logic [PW-1:0]                 ptr_q, ptr_d;

  logic [N_UNIT-1:0] rr_gnt;
  logic              rr_valid;
  logic [PW-1:0]     rr_idx;

  logic [N_UNIT-1:0] win_oh;
  logic              win_valid;
  logic [PW-1:0]     win_idx;
  logic              ptr_adv;
  logic [N_UNIT-1:0] accept;

  rr_arbiter #(
    .N  (N_UNIT),
    .PW (PW)
  ) u_rr (
    .req_i       (occ_q),
    .ptr_i       (ptr_q),
    .gnt_o       (rr_gnt),
    .gnt_valid_o (rr_valid),
    .gnt_idx_o   (rr_idx)
  );

  // Pick the winner: memory-unit override when enabled, round robin otherwise.
  // A memory-unit grant leaves the pointer alone so the others keep their turn.
  always_comb begin
    win_oh    = rr_gnt;
    win_valid = rr_valid;
    win_idx   = rr_idx;
    ptr_adv   = rr_valid;
    if (MEM_PRIO && occ_q[MEM_UNIT]) begin
      win_oh           = '0;
      win_oh[MEM_UNIT] = 1'b1;
      win_valid        = 1'b1;
      win_idx          = MEM_IDX;
      ptr_adv          = 1'b0;
    end
  end

  // Ready depends only on slot state and flush, never on req_valid.
  always_comb begin
    req_ready = rst_tag ? '0 : (~occ_q | win_oh);
    accept    = req_valid & req_ready;
  end

  // Next occupancy and pointer; invalid-tag requests are swallowed without
  // occupying the slot, and a flush empties everything.
  always_comb begin
    occ_d = occ_q & ~win_oh;
    for (int i = 0; i < N_UNIT; i++) begin
      if (accept[i]) occ_d[i] = (req_tag[i] != TAG_NONE);
    end
    if (rst_tag) occ_d = '0;

    ptr_d = ptr_q;
    if (rst_tag)      ptr_d = '0;
    else if (ptr_adv) ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + PW'(1);
  end

  // Slot occupancy and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
      ptr_q <= '0;
    end else begin
      occ_q <= occ_d;
      ptr_q <= ptr_d;
    end
  end

  // Slot payload capture on acceptance; contents are only meaningful while occupied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q  <= '0;
      data_q <= '0;
      rd_q   <= '0;
    end else begin
      for (int i = 0; i < N_UNIT; i++) begin
        if (accept[i]) begin
          tag_q[i]  <= req_tag[i];
          data_q[i] <= req_data[i];
          rd_q[i]   <= req_rd[i];
        end
      end
    end
  end

  // Registered broadcast; idle cycles keep the last data to avoid toggling the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= TAG_NONE;
      cdb_data  <= '0;
      cdb_rd    <= 1'b0;
    end else if (rst_tag || !win_valid) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= TAG_NONE;
      cdb_rd    <= 1'b0;
    end else begin
      cdb_valid <= 1'b1;
      cdb_tag   <= tag_q[win_idx];
      cdb_data  <= data_q[win_idx];
      cdb_rd    <= rd_q[win_idx];
    end
  end

endmodule
